// File: rtl/pose_update_sequencer_if.sv
// Grid map BRAM read port: the pose sequencer drives the strobe and address,
// and the map store returns the cell value.
interface pose_update_sequencer_if #(
    parameter int N = 24
);
    localparam int AW = $clog2(N*N);

    logic          map_rd_out;
    logic [AW-1:0] map_addr_out;
    logic [3:0]    map_data_in;

    modport master (output map_rd_out, output map_addr_out, input map_data_in);
    modport slave  (input map_rd_out, input map_addr_out, output map_data_in);
endinterface

// File: rtl/pose_update_sequencer.sv
// Per-frame player pose owner: one collision-checked move or one fixed-step rotation per frame.
// Build option WALL_SLIDE_EN: a map-blocked move retries X-only, then Y-only candidates.
module pose_update_sequencer #(
    parameter int                 N           = 24,
    parameter int                 MAP_LATENCY = 2,
    parameter logic signed [15:0] MOVE_SPEED  = 16'sh0100,
    parameter logic signed [15:0] COS_ROT     = 16'sh00FC,
    parameter logic signed [15:0] SIN_ROT     = 16'sh002C
) (
    input  logic                    pixel_clk_in,
    input  logic                    rst_in,
    input  logic                    frame_start_in,
    input  logic                    moveFwd,
    input  logic                    moveBack,
    input  logic                    rotLeft,
    input  logic                    rotRight,
    pose_update_sequencer_if.master map_bus,
    output logic signed [15:0]      posX,
    output logic signed [15:0]      posY,
    output logic signed [15:0]      dirX,
    output logic signed [15:0]      dirY,
    output logic signed [15:0]      planeX,
    output logic signed [15:0]      planeY,
    output logic                    valid_out,
    output logic                    blocked_out,
    output logic                    busy_out
);
    localparam int AW = $clog2(N*N);
    localparam int WW = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, CALC, READ, WAIT, ROT, COMMIT} state_t;
    typedef enum logic [2:0] {ACT_NONE, ACT_FWD, ACT_BACK, ACT_ROTL, ACT_ROTR} act_t;
    typedef struct packed {
        logic fwd;
        logic back;
        logic rot_l;
        logic rot_r;
    } btn_t;

    state_t             state, state_nxt;
    btn_t               btn;
    act_t               act;
    logic signed [15:0] cand_x, cand_y;
    logic               commit_ok;
    logic [1:0]         try_idx, try_nxt;
    logic [WW-1:0]      wait_cnt;
    logic [2:0]         rot_step;
    logic signed [31:0] acc [4];
    logic               move_commit, move_fail;

    function automatic logic in_range(input logic [15:0] v);
        return !v[15] && (int'(v[15:8]) < N);
    endfunction

    // Opposing buttons cancel before the priority pick.
    always_comb begin
        act = ACT_NONE;
        if (btn.fwd && !btn.back)        act = ACT_FWD;
        else if (btn.back && !btn.fwd)   act = ACT_BACK;
        else if (btn.rot_l && !btn.rot_r) act = ACT_ROTL;
        else if (btn.rot_r && !btn.rot_l) act = ACT_ROTR;
    end

    logic signed [31:0] step_x, step_y;
    logic signed [15:0] cx_c, cy_c;
    assign step_x = dirX * MOVE_SPEED;
    assign step_y = dirY * MOVE_SPEED;
    assign cx_c   = (act == ACT_BACK) ? posX - step_x[23:8] : posX + step_x[23:8];
    assign cy_c   = (act == ACT_BACK) ? posY - step_y[23:8] : posY + step_y[23:8];

    // try 0 = combined, 1 = X-only (keep posY), 2 = Y-only (keep posX).
    logic signed [15:0] ax, ay;
    assign ax = (try_idx == 2'd2) ? posX : cand_x;
    assign ay = (try_idx == 2'd1) ? posY : cand_y;

    assign map_bus.map_addr_out = AW'(int'(ay[15:8]) * N + int'(ax[15:8]));
    assign map_bus.map_rd_out   = (state == READ);
    assign busy_out             = (state != IDLE);
    assign valid_out            = (state == COMMIT) && commit_ok;
    assign blocked_out          = (state == COMMIT) && !commit_ok;

    // Rotation schedule: steps 0-3 build dir, 4-7 build plane; odd step of each pair
    // at index 1 is the subtracted cross term.
    logic signed [15:0] sin_eff, mul_a, mul_b, vx, vy;
    logic signed [31:0] prod, acc_sum;
    logic [1:0]         acc_sel;
    assign sin_eff = (act == ACT_ROTR) ? -SIN_ROT : SIN_ROT;
    assign vx      = rot_step[2] ? planeX : dirX;
    assign vy      = rot_step[2] ? planeY : dirY;

    always_comb begin
        mul_a = vx;
        mul_b = COS_ROT;
        case (rot_step[1:0])
            2'd0:    begin mul_a = vx; mul_b = COS_ROT; end
            2'd1:    begin mul_a = vy; mul_b = sin_eff; end
            2'd2:    begin mul_a = vx; mul_b = sin_eff; end
            default: begin mul_a = vy; mul_b = COS_ROT; end
        endcase
    end

    assign prod    = mul_a * mul_b;
    assign acc_sel = rot_step[2:1];
    assign acc_sum = (rot_step[1:0] == 2'd1) ? acc[acc_sel] - prod : acc[acc_sel] + prod;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        try_nxt     = try_idx;
        move_commit = 1'b0;
        move_fail   = 1'b0;
        case (state)
            IDLE: if (frame_start_in) state_nxt = CALC;
            CALC: begin
                try_nxt = 2'd0;
                case (act)
                    ACT_FWD, ACT_BACK: begin
                        if (in_range(cx_c) && in_range(cy_c)) begin
                            state_nxt = READ;
                        end else begin
                            state_nxt = COMMIT;
                            move_fail = 1'b1;
                        end
                    end
                    ACT_ROTL, ACT_ROTR: state_nxt = ROT;
                    default:            state_nxt = IDLE;
                endcase
            end
            READ: state_nxt = WAIT;
            WAIT: begin
                if (wait_cnt == WW'(MAP_LATENCY - 1)) begin
                    state_nxt = COMMIT;
                    if (map_bus.map_data_in == 4'd0) begin
                        move_commit = 1'b1;
`ifdef WALL_SLIDE_EN
                    // Each axis was range-checked as part of the combined candidate,
                    // so both single-axis retries are always in bounds.
                    end else if (try_idx != 2'd2) begin
                        state_nxt = READ;
                        try_nxt   = try_idx + 2'd1;
`endif
                    end else begin
                        move_fail = 1'b1;
                    end
                end
            end
            ROT:     if (rot_step == 3'd7) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            posX      <= 16'sh0C80;
            posY      <= 16'sh0180;
            dirX      <= 16'sh0000;
            dirY      <= 16'sh0100;
            planeX    <= 16'sh0000;
            planeY    <= 16'sh00A9;
            btn       <= '0;
            cand_x    <= '0;
            cand_y    <= '0;
            commit_ok <= 1'b0;
            try_idx   <= '0;
            wait_cnt  <= '0;
            rot_step  <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            try_idx <= try_nxt;
            if (state == IDLE && frame_start_in)
                btn <= {moveFwd, moveBack, rotLeft, rotRight};
            if (state == CALC) begin
                cand_x   <= cx_c;
                cand_y   <= cy_c;
                rot_step <= '0;
                for (int i = 0; i < 4; i++) acc[i] <= '0;
            end
            if (state == READ) wait_cnt <= '0;
            if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (move_fail) commit_ok <= 1'b0;
            if (move_commit) begin
                commit_ok <= 1'b1;
                posX      <= ax;
                posY      <= ay;
            end
            if (state == ROT) begin
                acc[acc_sel] <= acc_sum;
                rot_step     <= rot_step + 3'd1;
                // Last product lands straight into planeY; the other three are already final.
                if (rot_step == 3'd7) begin
                    commit_ok <= 1'b1;
                    dirX      <= acc[0][23:8];
                    dirY      <= acc[1][23:8];
                    planeX    <= acc[2][23:8];
                    planeY    <= acc_sum[23:8];
                end
            end
        end
    end
endmodule

// File: tb/tb_pose_update_sequencer.sv
// Directed bench for pose_update_sequencer with a two-cycle-latency map model.
module tb_pose_update_sequencer;
    localparam int N  = 24;
    localparam int AW = $clog2(N*N);

    logic clk = 1'b0, rst_n = 1'b0, fs = 1'b0;
    logic mf = 1'b0, mb = 1'b0, rl = 1'b0, rr = 1'b0;
    logic [15:0] posX, posY, dirX, dirY, planeX, planeY;
    logic valid_out, blocked_out, busy_out;
    logic [3:0] mem [N*N];
    logic [3:0] d1, d2;

    int checks = 0, errors = 0, glitches = 0, stray = 0;
    int t_valid, t_blk, t_rd, n_valid, n_blk, n_rd;
    logic [AW-1:0] rd_addr;
    logic busy_t1;

    pose_update_sequencer_if #(.N(N)) bus ();

    pose_update_sequencer dut (
        .pixel_clk_in(clk), .rst_in(rst_n), .frame_start_in(fs),
        .moveFwd(mf), .moveBack(mb), .rotLeft(rl), .rotRight(rr),
        .map_bus(bus),
        .posX(posX), .posY(posY), .dirX(dirX), .dirY(dirY),
        .planeX(planeX), .planeY(planeY),
        .valid_out(valid_out), .blocked_out(blocked_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    // Data is only meaningful MAP_LATENCY cycles after a strobe; otherwise reads back as wall.
    always @(posedge clk) begin
        d1 <= bus.map_rd_out ? mem[bus.map_addr_out] : 4'hF;
        d2 <= d1;
    end
    assign bus.map_data_in = d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fs = 1'b0; mf = 1'b0; mb = 1'b0; rl = 1'b0; rr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulses frame_start at cycle T, then samples cycles T+1..T+ncyc at negedges.
    task automatic run_frame(input int refire, input int ncyc);
        logic [95:0] prev;
        t_valid = -1; t_blk = -1; t_rd = -1; n_valid = 0; n_blk = 0; n_rd = 0; rd_addr = '0;
        prev = {posX, posY, dirX, dirY, planeX, planeY};
        fs = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fs = 1'b0;
        busy_t1 = busy_out;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) @(negedge clk);
            fs = (k == refire);
            if (valid_out) begin if (t_valid < 0) t_valid = k; n_valid++; end
            if (blocked_out) begin if (t_blk < 0) t_blk = k; n_blk++; end
            if (bus.map_rd_out) begin
                if (t_rd < 0) begin t_rd = k; rd_addr = bus.map_addr_out; end
                n_rd++;
            end
            if ({posX, posY, dirX, dirY, planeX, planeY} != prev && !valid_out) glitches++;
            prev = {posX, posY, dirX, dirY, planeX, planeY};
        end
        fs = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N*N; i++) mem[i] = 4'd0;

        // Reset state
        @(negedge clk);
        chk("rst_posX", posX, 16'h0C80);
        chk("rst_posY", posY, 16'h0180);
        chk("rst_dirX", dirX, 16'h0000);
        chk("rst_dirY", dirY, 16'h0100);
        chk("rst_planeX", planeX, 16'h0000);
        chk("rst_planeY", planeY, 16'h00A9);
        chk("rst_strobes", {busy_out, valid_out, blocked_out, bus.map_rd_out}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Forward into an empty cell
        mf = 1'b1;
        run_frame(0, 12);
        mf = 1'b0;
        chk("fwd_busy_t1", busy_t1, 1);
        chk("fwd_t_rd", t_rd, 2);
        chk("fwd_addr", rd_addr, 60);
        chk("fwd_n_rd", n_rd, 1);
        chk("fwd_t_valid", t_valid, 5);
        chk("fwd_n_valid", n_valid, 1);
        chk("fwd_n_blk", n_blk, 0);
        chk("fwd_posY", posY, 16'h0280);
        chk("fwd_posX", posX, 16'h0C80);
        chk("fwd_busy_end", busy_out, 0);

        // Forward into a wall
        do_reset();
        mem[60] = 4'd1;
        mf = 1'b1;
        run_frame(0, 12);
        mf = 1'b0;
        mem[60] = 4'd0;
        chk("wall_t_blk", t_blk, 5);
        chk("wall_n_valid", n_valid, 0);
        chk("wall_posY", posY, 16'h0180);

        // Back twice: second leaves the map
        do_reset();
        mb = 1'b1;
        run_frame(0, 12);
        chk("back1_t_valid", t_valid, 5);
        chk("back1_posY", posY, 16'h0080);
        run_frame(0, 12);
        mb = 1'b0;
        chk("back2_t_blk", t_blk, 2);
        chk("back2_n_rd", n_rd, 0);
        chk("back2_n_valid", n_valid, 0);
        chk("back2_posY", posY, 16'h0080);

        // Rotate left
        do_reset();
        rl = 1'b1;
        run_frame(0, 14);
        rl = 1'b0;
        chk("rotl_t_valid", t_valid, 10);
        chk("rotl_dirX", dirX, 16'hFFD4);
        chk("rotl_dirY", dirY, 16'h00FC);
        chk("rotl_planeX", planeX, 16'hFFE2);
        chk("rotl_planeY", planeY, 16'h00A6);
        chk("rotl_pos", {posX, posY}, {16'h0C80, 16'h0180});

        // Moves cancel, rotate right wins; re-pulse at T+4 ignored
        do_reset();
        mf = 1'b1; mb = 1'b1; rr = 1'b1;
        run_frame(4, 24);
        mf = 1'b0; mb = 1'b0; rr = 1'b0;
        chk("rotr_t_valid", t_valid, 10);
        chk("rotr_n_valid", n_valid, 1);
        chk("rotr_dirX", dirX, 16'h002C);
        chk("rotr_dirY", dirY, 16'h00FC);
        chk("rotr_planeX", planeX, 16'h001D);
        chk("rotr_planeY", planeY, 16'h00A6);

        // No action after cancellation
        mf = 1'b1; mb = 1'b1;
        run_frame(0, 6);
        mf = 1'b0; mb = 1'b0;
        chk("none_busy_t1", busy_t1, 1);
        chk("none_strobes", n_valid + n_blk + n_rd, 0);
        chk("none_busy_end", busy_out, 0);

        // Reset in the middle of a move
        do_reset();
        mf = 1'b1;
        fs = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_posY", posY, 16'h0180);
        chk("midrst_busy", busy_out, 0);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst_n = 1'b1;
            @(negedge clk);
            if (valid_out || blocked_out || bus.map_rd_out) stray++;
        end
        chk("midrst_stray", stray, 0);
        run_frame(0, 12);
        mf = 1'b0;
        chk("midrst_next_t_valid", t_valid, 5);
        chk("midrst_next_posY", posY, 16'h0280);

        // Diagonal move into a wall after one left rotation
        do_reset();
        rl = 1'b1;
        run_frame(0, 14);
        rl = 1'b0;
        mem[60] = 4'd1;
        mf = 1'b1;
        run_frame(0, 16);
        mf = 1'b0;
        mem[60] = 4'd0;
`ifdef WALL_SLIDE_EN
        chk("slide_t_valid", t_valid, 8);
        chk("slide_n_rd", n_rd, 2);
        chk("slide_n_blk", n_blk, 0);
        chk("slide_pos", {posX, posY}, {16'h0C54, 16'h0180});
`else
        chk("diag_t_blk", t_blk, 5);
        chk("diag_n_rd", n_rd, 1);
        chk("diag_n_valid", n_valid, 0);
        chk("diag_pos", {posX, posY}, {16'h0C80, 16'h0180});
`endif

        chk("pose_only_on_valid", glitches, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pose_update_sequencer.md
Name: pose_update_sequencer

Overview:
- Per-frame sequencer that owns the player pose (position, direction, camera plane) and applies at most one movement or rotation per frame.
- Movement candidates are collision-checked against the grid map BRAM through a read port before commit.
- Rotation uses a single time-shared signed 16x16 multiplier.
- Sits between the debounced button inputs and the raycaster pose inputs.

Parameters:
- N, 24, map side length in cells (map address = mapY*N + mapX).
- MAP_LATENCY, 2, cycles from map_rd_out to valid map_data_in.
- MOVE_SPEED, 16'h0100, Q8.8 step scale.
- COS_ROT, 16'h00FC, Q8.8 cosine of the fixed rotation step.
- SIN_ROT, 16'h002C, Q8.8 sine of the fixed rotation step.

Ports:
- pixel_clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-low
- frame_start_in  in  1  one-cycle pulse per frame; starts a sequence
- moveFwd, moveBack, rotLeft, rotRight  in  1 each  level button requests
- map_rd_out  out  1  one-cycle map read strobe
- map_addr_out  out  $clog2(N*N)  map cell address
- map_data_in  in  4  cell value; 0 = empty
- posX, posY, dirX, dirY, planeX, planeY  out  16 each  signed Q8.8 pose
- valid_out  out  1  one-cycle pulse when the pose changed
- blocked_out  out  1  one-cycle pulse when a move was rejected
- busy_out  out  1  high while a sequence is in flight

Behaviour:
- Reset (rst_in low, asynchronous):
  - posX=16'h0C80, posY=16'h0180, dirX=0, dirY=16'h0100, planeX=0, planeY=16'h00A9.
  - State IDLE; all strobes 0; busy_out=0.
  - Reset mid-sequence discards the sequence; no valid_out or blocked_out follows.
- States: IDLE, CALC, READ, WAIT, ROT, COMMIT.
- IDLE:
  - frame_start_in high at cycle T latches the buttons and goes to CALC.
  - busy_out is high from T+1 until the cycle after the terminal strobe.
  - frame_start_in while busy is ignored.
- Action select (from latched buttons):
  - moveFwd&moveBack both high cancel each other, as do rotLeft&rotRight.
  - Priority: fwd > back > rotLeft > rotRight.
  - No action: return to IDLE with no strobe.
- Move:
  - CALC forms delta = (dir*MOVE_SPEED)[23:8], 32-bit signed product.
  - Candidate = pos ± delta, 16-bit wraparound.
  - Bounds check: if either candidate is negative or candidate[15:8] >= N, assert blocked_out at T+2 and return to IDLE. No map read is issued.
  - Otherwise READ: map_rd_out=1 for one cycle at T+2, with map_addr_out = candY[15:8]*N + candX[15:8].
  - WAIT holds MAP_LATENCY cycles.
  - map_data_in==0: commit both axes, valid_out at T+3+MAP_LATENCY.
  - map_data_in!=0: blocked_out at the same cycle; pose unchanged.
- Rotate:
  - Left uses +θ: dX' = dX*C - dY*S, dY' = dX*S + dY*C; plane rotated identically. Right uses -θ (S negated).
  - ROT runs 8 cycles, one signed product per cycle, accumulated in 32-bit signed accumulators.
  - Result = acc[23:8] (floor truncation).
  - All four vectors commit together; valid_out at T+10. posX/posY untouched.
- Pose outputs change only on the valid_out cycle.

Optional Feature:
- Macro WALL_SLIDE_EN.
- Defined: when a combined move is blocked by map data, retry an X-only candidate (posX+Δx, posY), then a Y-only candidate (posX, posY+Δy). Each retry is a further READ+WAIT. The first empty cell commits with valid_out. blocked_out fires only if all three candidates fail. Bounds failures on a retry skip that retry.
- Undefined: single candidate only, as above.

Test Plan:
- Reset, moveFwd, frame_start at T, map_data_in=0 -> map_addr_out=2*24+12=60 at T+2, posY=16'h0280, posX unchanged, valid_out at T+5.
- Reset, moveFwd, map_data_in=1 -> blocked_out at T+5, pose equals reset values, no valid_out.
- Reset, moveBack twice with empty map -> first gives posY=16'h0080; second gives candidate 16'hFF80, blocked_out at T+2 and map_rd_out never asserted.
- Reset, rotLeft -> at T+10: dirX=16'hFFD4, dirY=16'h00FC, planeX=16'hFFE2, planeY=16'h00A6.
- moveFwd+moveBack+rotRight together -> rotate right: dirX=16'h002C, dirY=16'h00FC. frame_start pulsed again at T+4 is ignored; single valid_out.
- rst_in low at T+3 of a move -> reset pose immediately, no strobes, next frame_start sequences normally. With WALL_SLIDE_EN: dir=(0x00B5,0x00B5), diagonal cell wall, X-only cell empty -> posX advances, posY unchanged, valid_out.
